// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: default resolution, fill FSM states,
// colour type and the packing of one framebuffer write word.
package fb_pkg;

  localparam int H_RES_DEFAULT = 640;
  localparam int V_RES_DEFAULT = 480;

  typedef enum logic [1:0] {IDLE, SETUP, WRITE, DONE} state_t;

  typedef logic [23:0] rgb_t;

  // Bit 0 marks the final pixel of a frame; the colour sits directly above it.
  function automatic logic [31:0] pack_writedata(input rgb_t rgb, input logic flag);
    return {7'b0, rgb, flag};
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Combinational pixel coordinate to linear framebuffer address (19 bits).
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int H_RES = H_RES_DEFAULT
) (
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic [18:0] addr
);

  // y*640 = (y<<9) + (y<<7), which avoids a multiplier for the common mode.
  generate
    if (H_RES == 640) begin : g_shift
      assign addr = {9'b0, x} + {y, 9'b0} + {2'b0, y, 7'b0};
    end else begin : g_mult
      assign addr = {9'b0, x} + (19'(y) * 19'(H_RES));
    end
  endgenerate

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: clips a command to the visible area and writes one
// pixel per accepted Avalon-MM cycle in row-major order.
module rect_fill_engine
  import fb_pkg::*;
#(
  parameter int H_RES = H_RES_DEFAULT,
  parameter int V_RES = V_RES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_x0,
  input  logic [9:0]  cmd_y0,
  input  logic [9:0]  cmd_w,
  input  logic [9:0]  cmd_h,
  input  rgb_t        cmd_rgb,
  input  logic        cmd_last,
  output logic        fb_chipselect,
  output logic        fb_write,
  output logic [31:0] fb_address,
  output logic [31:0] fb_writedata,
  input  logic        fb_waitrequest,
  output logic        busy,
  output logic        done
);

  localparam logic [10:0] H_LIM = 11'(H_RES);
  localparam logic [10:0] V_LIM = 11'(V_RES);

  state_t      state;
  logic [9:0]  x0_r, y0_r, w_r, h_r;
  rgb_t        rgb_r;
  logic        last_r;
  logic [9:0]  x, y;

  logic [10:0] x_sum, y_sum, x_end, y_end;
  logic        empty, at_row_end, at_last, next_last;
  logic [9:0]  next_x, next_y;
  logic [18:0] next_addr;

  // Clip bounds are 11 bits wide so x0+w cannot wrap before the min().
  always_comb begin
    x_sum      = {1'b0, x0_r} + {1'b0, w_r};
    y_sum      = {1'b0, y0_r} + {1'b0, h_r};
    x_end      = (x_sum > H_LIM) ? H_LIM : x_sum;
    y_end      = (y_sum > V_LIM) ? V_LIM : y_sum;
    empty      = ({1'b0, x0_r} >= H_LIM) || ({1'b0, y0_r} >= V_LIM) ||
                 (w_r == 10'd0) || (h_r == 10'd0);
    at_row_end = ({1'b0, x} == x_end - 11'd1);
    at_last    = at_row_end && ({1'b0, y} == y_end - 11'd1);
    next_x     = x + 10'd1;
    next_y     = y;
    if (state == SETUP) begin
      next_x = x0_r;
      next_y = y0_r;
    end else if (at_row_end) begin
      next_x = x0_r;
      next_y = y + 10'd1;
    end
    next_last  = last_r && ({1'b0, next_x} == x_end - 11'd1) &&
                 ({1'b0, next_y} == y_end - 11'd1);
  end

  fb_addr_gen #(.H_RES(H_RES)) u_addr_gen (
    .x    (next_x),
    .y    (next_y),
    .addr (next_addr)
  );

  // Outputs are registered one pixel ahead, so the bus sees the coordinate
  // that the counters are about to hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cmd_ready     <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      fb_chipselect <= 1'b0;
      fb_write      <= 1'b0;
      fb_address    <= 32'd0;
      fb_writedata  <= 32'd0;
      x0_r          <= 10'd0;
      y0_r          <= 10'd0;
      w_r           <= 10'd0;
      h_r           <= 10'd0;
      rgb_r         <= '0;
      last_r        <= 1'b0;
      x             <= 10'd0;
      y             <= 10'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            x0_r      <= cmd_x0;
            y0_r      <= cmd_y0;
            w_r       <= cmd_w;
            h_r       <= cmd_h;
            rgb_r     <= cmd_rgb;
            last_r    <= cmd_last;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (empty) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            x             <= next_x;
            y             <= next_y;
            fb_chipselect <= 1'b1;
            fb_write      <= 1'b1;
            fb_address    <= {13'd0, next_addr};
            fb_writedata  <= pack_writedata(rgb_r, next_last);
            state         <= WRITE;
          end
        end
        WRITE: begin
          if (!fb_waitrequest) begin
            if (at_last) begin
              fb_chipselect <= 1'b0;
              fb_write      <= 1'b0;
              fb_address    <= 32'd0;
              fb_writedata  <= 32'd0;
              done          <= 1'b1;
              state         <= DONE;
            end else begin
              x            <= next_x;
              y            <= next_y;
              fb_address   <= {13'd0, next_addr};
              fb_writedata <= pack_writedata(rgb_r, next_last);
            end
          end
        end
        DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine: directed vector table, stall,
// held-valid and reset sequences, then randomized commands against a model.
module tb_rect_fill_engine;

  typedef struct {
    logic [9:0]  x0, y0, w, h;
    logic [23:0] rgb;
    logic        last;
    int          n;
    logic [31:0] first_addr, last_addr;
    logic        last_flag;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_x0 = '0, cmd_y0 = '0, cmd_w = '0, cmd_h = '0;
  logic [23:0] cmd_rgb = '0;
  logic        cmd_last = 1'b0;
  logic        fb_chipselect, fb_write;
  logic [31:0] fb_address, fb_writedata;
  logic        fb_waitrequest = 1'b0;
  logic        busy, done;

  int  n_cmp = 0, n_fail = 0;
  int  cyc = 0;
  int  done_cnt = 0, done_cyc = 0, busy_rises = 0, strobe_err = 0;
  logic busy_at_done = 1'b0, prev_busy = 1'b0;
  bit  rand_stall = 1'b0;
  wr_t wr_q[$];
  wr_t exp_q[$];
  vec_t vecs[9];

  rect_fill_engine dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_x0         (cmd_x0),
    .cmd_y0         (cmd_y0),
    .cmd_w          (cmd_w),
    .cmd_h          (cmd_h),
    .cmd_rgb        (cmd_rgb),
    .cmd_last       (cmd_last),
    .fb_chipselect  (fb_chipselect),
    .fb_write       (fb_write),
    .fb_address     (fb_address),
    .fb_writedata   (fb_writedata),
    .fb_waitrequest (fb_waitrequest),
    .busy           (busy),
    .done           (done)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // A write seen here with waitrequest low is the one the next posedge accepts.
  initial forever begin
    @(negedge clk);
    if (fb_write && !fb_waitrequest) wr_q.push_back('{fb_address, fb_writedata, cyc});
    if (fb_write !== fb_chipselect) strobe_err++;
    if (done) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
    if (busy && !prev_busy) busy_rises++;
    prev_busy = busy;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_stall) fb_waitrequest = ($urandom_range(0, 3) == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: every visible pixel of the clipped rectangle, row by row.
  task automatic build_model(input int x0, input int y0, input int w, input int h,
                             input logic [23:0] rgb, input logic last);
    int xe, ye, n, k;
    exp_q.delete();
    if (x0 >= 640 || y0 >= 480 || w == 0 || h == 0) return;
    xe = (x0 + w > 640) ? 640 : x0 + w;
    ye = (y0 + h > 480) ? 480 : y0 + h;
    n  = (xe - x0) * (ye - y0);
    k  = 0;
    for (int yy = y0; yy < ye; yy++) begin
      for (int xx = x0; xx < xe; xx++) begin
        exp_q.push_back('{32'(yy * 640 + xx), {7'b0, rgb, (last && k == n - 1)}, 0});
        k++;
      end
    end
  endtask

  task automatic clear_stats();
    wr_q.delete();
    done_cnt     = 0;
    busy_rises   = 0;
    busy_at_done = 1'b0;
  endtask

  task automatic start_cmd(input logic [9:0] x0, input logic [9:0] y0, input logic [9:0] w,
                           input logic [9:0] h, input logic [23:0] rgb, input logic last,
                           output int acc);
    int t = 0;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      #2;
      t++;
    end
    if (!cmd_ready) check("ready_timeout", {31'd0, cmd_ready}, 32'd1);
    cmd_x0 = x0; cmd_y0 = y0; cmd_w = w; cmd_h = h; cmd_rgb = rgb; cmd_last = last;
    cmd_valid = 1'b1;
    acc = cyc;
    @(negedge clk);
    #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output int rdy);
    int t = 0;
    do begin
      @(negedge clk);
      #2;
      t++;
    end while (!cmd_ready && t < 500);
    if (!cmd_ready) check("idle_timeout", {31'd0, cmd_ready}, 32'd1);
    rdy = cyc;
  endtask

  task automatic verify(input string tag, input logic [9:0] x0, input logic [9:0] y0,
                        input logic [9:0] w, input logic [9:0] h, input logic [23:0] rgb,
                        input logic last, input int acc, input int rdy, input bit timed);
    int m, n;
    build_model(x0, y0, w, h, rgb, last);
    n = exp_q.size();
    check($sformatf("%s n_writes", tag), wr_q.size(), n);
    m = (wr_q.size() < n) ? wr_q.size() : n;
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s addr[%0d]", tag, i), wr_q[i].addr, exp_q[i].addr);
      check($sformatf("%s data[%0d]", tag, i), wr_q[i].data, exp_q[i].data);
    end
    check($sformatf("%s done_pulses", tag), done_cnt, 1);
    check($sformatf("%s busy_at_done", tag), {31'd0, busy_at_done}, 32'd1);
    if (timed) begin
      check($sformatf("%s done_latency", tag), done_cyc - acc, n + 2);
      check($sformatf("%s total_cycles", tag), rdy - acc, n + 3);
      if (wr_q.size() > 0) begin
        check($sformatf("%s first_latency", tag), wr_q[0].cyc - acc, 2);
        check($sformatf("%s back_to_back", tag), wr_q[wr_q.size()-1].cyc - wr_q[0].cyc,
              wr_q.size() - 1);
      end
    end
  endtask

  task automatic run_vec(input int i);
    int acc, rdy;
    string tag;
    tag = $sformatf("vec%0d", i);
    clear_stats();
    start_cmd(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].rgb, vecs[i].last, acc);
    wait_idle(rdy);
    verify(tag, vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].rgb, vecs[i].last,
           acc, rdy, 1'b1);
    check({tag, " table_n"}, wr_q.size(), vecs[i].n);
    if (vecs[i].n > 0 && wr_q.size() > 0) begin
      check({tag, " table_first"}, wr_q[0].addr, vecs[i].first_addr);
      check({tag, " table_last"}, wr_q[wr_q.size()-1].addr, vecs[i].last_addr);
      check({tag, " table_flag"}, {31'd0, wr_q[wr_q.size()-1].data[0]}, {31'd0, vecs[i].last_flag});
    end
  endtask

  initial begin
    int acc, rdy, t;
    logic [9:0] rx0, ry0, rw, rh;
    logic [23:0] rrgb;
    logic rlast;

    vecs[0] = '{10'd10,  10'd20,  10'd3, 10'd2, 24'hFF0000, 1'b0, 6, 32'd12810,  32'd13452,  1'b0};
    vecs[1] = '{10'd638, 10'd479, 10'd5, 10'd5, 24'h00FF00, 1'b0, 2, 32'd307198, 32'd307199, 1'b0};
    vecs[2] = '{10'd5,   10'd5,   10'd0, 10'd4, 24'h123456, 1'b1, 0, 32'd0,      32'd0,      1'b0};
    vecs[3] = '{10'd100, 10'd200, 10'd2, 10'd1, 24'hABCDEF, 1'b1, 2, 32'd128100, 32'd128101, 1'b1};
    vecs[4] = '{10'd100, 10'd200, 10'd2, 10'd1, 24'hABCDEF, 1'b0, 2, 32'd128100, 32'd128101, 1'b0};
    vecs[5] = '{10'd640, 10'd10,  10'd4, 10'd4, 24'h0000FF, 1'b0, 0, 32'd0,      32'd0,      1'b0};
    vecs[6] = '{10'd0,   10'd0,   10'd4, 10'd0, 24'h0000FF, 1'b0, 0, 32'd0,      32'd0,      1'b0};
    vecs[7] = '{10'd0,   10'd0,   10'd1, 10'd1, 24'h808080, 1'b1, 1, 32'd0,      32'd0,      1'b1};
    vecs[8] = '{10'd639, 10'd0,   10'd1, 10'd3, 24'h0F0F0F, 1'b0, 3, 32'd639,    32'd1919,   1'b0};

    repeat (3) @(negedge clk);
    #2;
    check("rst fb_write", {31'd0, fb_write}, 32'd0);
    check("rst fb_chipselect", {31'd0, fb_chipselect}, 32'd0);
    check("rst fb_address", fb_address, 32'd0);
    check("rst fb_writedata", fb_writedata, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    #2;
    check("rst cmd_ready", {31'd0, cmd_ready}, 32'd1);

    for (int i = 0; i < 9; i++) run_vec(i);

    // Hold waitrequest for three cycles while the second pixel is on the bus.
    clear_stats();
    start_cmd(10'd10, 10'd20, 10'd3, 10'd2, 24'hFF0000, 1'b0, acc);
    t = 0;
    while (wr_q.size() < 1 && t < 20) begin
      @(negedge clk);
      #2;
      t++;
    end
    @(posedge clk);
    #1;
    fb_waitrequest = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #2;
      check("stall addr", fb_address, 32'd12811);
      check("stall data", fb_writedata, {7'b0, 24'hFF0000, 1'b0});
      @(posedge clk);
      #1;
    end
    fb_waitrequest = 1'b0;
    wait_idle(rdy);
    verify("stall", 10'd10, 10'd20, 10'd3, 10'd2, 24'hFF0000, 1'b0, acc, rdy, 1'b0);
    check("stall done_latency", done_cyc - acc, 11);

    // cmd_valid held through the whole command must be taken exactly once.
    clear_stats();
    cmd_x0 = 10'd1; cmd_y0 = 10'd1; cmd_w = 10'd2; cmd_h = 10'd2;
    cmd_rgb = 24'h00AA55; cmd_last = 1'b0;
    cmd_valid = 1'b1;
    acc = cyc;
    t = 0;
    while (done_cnt == 0 && t < 50) begin
      @(negedge clk);
      #2;
      t++;
    end
    cmd_valid = 1'b0;
    wait_idle(rdy);
    check("held accepts", busy_rises, 1);
    verify("held", 10'd1, 10'd1, 10'd2, 10'd2, 24'h00AA55, 1'b0, acc, rdy, 1'b1);

    // Reset after four of six writes.
    clear_stats();
    start_cmd(10'd10, 10'd20, 10'd3, 10'd2, 24'h445566, 1'b1, acc);
    t = 0;
    while (wr_q.size() < 4 && t < 20) begin
      @(negedge clk);
      #2;
      t++;
    end
    reset = 1'b0;
    #1;
    check("midrst fb_write", {31'd0, fb_write}, 32'd0);
    check("midrst fb_chipselect", {31'd0, fb_chipselect}, 32'd0);
    check("midrst fb_address", fb_address, 32'd0);
    check("midrst fb_writedata", fb_writedata, 32'd0);
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    #2;
    check("midrst writes", wr_q.size(), 4);
    build_model(10, 20, 3, 2, 24'h445566, 1'b1);
    for (int i = 0; i < 4 && i < wr_q.size(); i++)
      check($sformatf("midrst addr[%0d]", i), wr_q[i].addr, exp_q[i].addr);
    reset = 1'b1;
    @(negedge clk);
    #2;
    check("midrst cmd_ready", {31'd0, cmd_ready}, 32'd1);
    run_vec(0);

    rand_stall = 1'b1;
    for (int r = 0; r < 40; r++) begin
      rx0   = 10'($urandom_range(0, 660));
      ry0   = 10'($urandom_range(0, 500));
      rw    = 10'($urandom_range(0, 8));
      rh    = 10'($urandom_range(0, 5));
      rrgb  = 24'($urandom());
      rlast = 1'($urandom_range(0, 1));
      clear_stats();
      start_cmd(rx0, ry0, rw, rh, rrgb, rlast, acc);
      wait_idle(rdy);
      verify($sformatf("rand%0d", r), rx0, ry0, rw, rh, rrgb, rlast, acc, rdy, 1'b0);
    end
    rand_stall = 1'b0;
    fb_waitrequest = 1'b0;

    check("strobes match", strobe_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
